// File: rtl/mycpu_pkg.sv
// Shared definitions for the mycpu memory request path: requester ids and the
// outstanding-queue entry layout used by mem_req_arbiter and arb_id_fifo.
package mycpu_pkg;

  localparam logic INST_ID = 1'b0;
  localparam logic DATA_ID = 1'b1;

  typedef struct packed {
    logic cancel;
    logic id;
  } fifo_entry_t;

endpackage

// File: rtl/arb_id_fifo.sv
// Outstanding-request queue: records which requester owns each accepted bus request.
// With ARB_FLUSH_CANCEL_EN defined, each entry also carries a cancel bit set by flush.
module arb_id_fifo
  import mycpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic resetn,
  input  logic push_i,
  input  logic push_id_i,
  input  logic pop_i,
`ifdef ARB_FLUSH_CANCEL_EN
  input  logic flush_i,
`endif
  output logic full_o,
  output logic empty_o,
  output logic head_id_o,
  output logic head_cancel_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

`ifdef ARB_FLUSH_CANCEL_EN
  fifo_entry_t      mem_q [DEPTH];
  logic [DEPTH-1:0] valid;

  // An entry is live when its distance from the read pointer is below count.
  always_comb begin
    valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      valid[i] = ({1'b0, PW'(i) - rd_ptr_q}) < count_q;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (do_push && (wr_ptr_q == PW'(i))) begin
          mem_q[i].id     <= push_id_i;
          mem_q[i].cancel <= flush_i && (push_id_i == INST_ID);
        end else if (flush_i && valid[i] && (mem_q[i].id == INST_ID)) begin
          mem_q[i].cancel <= 1'b1;
        end
      end
    end
  end

  assign head_id_o     = mem_q[rd_ptr_q].id;
  assign head_cancel_o = mem_q[rd_ptr_q].cancel;
`else
  logic id_q [DEPTH];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) id_q[i] <= INST_ID;
    end else if (do_push) begin
      id_q[wr_ptr_q] <= push_id_i;
    end
  end

  assign head_id_o     = id_q[rd_ptr_q];
  assign head_cancel_o = 1'b0;
`endif

endmodule

// File: rtl/mem_req_arbiter.sv
// Two-requester (inst/data) arbiter onto one SRAM-like bus with in-order response routing.
// ARB_FLUSH_CANCEL_EN enables flush-based cancellation of in-flight inst responses.
module mem_req_arbiter
  import mycpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  input  logic        flush,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [1:0]  bus_size,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata
);

  logic lock_q, lock_d;
  logic lock_id_q, lock_id_d;
  logic grant_id, grant_req, sel_data;
  logic full, empty, head_id, head_cancel;
  logic handshake, pop;

  // A request that has been presented but not accepted keeps the grant.
  always_comb begin
    if (lock_q)        grant_id = lock_id_q;
    else if (data_req) grant_id = DATA_ID;
    else               grant_id = INST_ID;
  end

  assign sel_data  = (grant_id == DATA_ID);
  assign grant_req = sel_data ? data_req : inst_req;
  assign bus_req   = resetn && grant_req && !full;
  assign bus_wr    = sel_data ? data_wr    : inst_wr;
  assign bus_size  = sel_data ? data_size  : inst_size;
  assign bus_wstrb = sel_data ? data_wstrb : inst_wstrb;
  assign bus_addr  = sel_data ? data_addr  : inst_addr;
  assign bus_wdata = sel_data ? data_wdata : inst_wdata;

  assign handshake    = bus_req && bus_addr_ok;
  assign inst_addr_ok = handshake && !sel_data;
  assign data_addr_ok = handshake && sel_data;

  assign pop          = resetn && bus_data_ok && !empty;
  assign inst_data_ok = pop && !head_cancel && (head_id == INST_ID);
  assign data_data_ok = pop && !head_cancel && (head_id == DATA_ID);
  assign inst_rdata   = bus_rdata;
  assign data_rdata   = bus_rdata;

  always_comb begin
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
    if (handshake) begin
      lock_d = 1'b0;
    end else if (bus_req) begin
      lock_d    = 1'b1;
      lock_id_d = grant_id;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lock_q    <= 1'b0;
      lock_id_q <= INST_ID;
    end else begin
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
    end
  end

`ifndef ARB_FLUSH_CANCEL_EN
  logic unused_flush;
  assign unused_flush = flush;
`endif

  arb_id_fifo #(
    .DEPTH(DEPTH)
  ) u_id_fifo (
    .clk          (clk),
    .resetn       (resetn),
    .push_i       (handshake),
    .push_id_i    (grant_id),
    .pop_i        (pop),
`ifdef ARB_FLUSH_CANCEL_EN
    .flush_i      (flush),
`endif
    .full_o       (full),
    .empty_o      (empty),
    .head_id_o    (head_id),
    .head_cancel_o(head_cancel)
  );

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Bench for mem_req_arbiter: directed scenarios followed by random traffic, all
// checked against a queue-based reference of outstanding requests.
module tb_mem_req_arbiter;

  localparam int DEPTH = 4;

  logic        clk, resetn;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size;
  logic [3:0]  inst_wstrb, data_wstrb;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        flush;
  logic        bus_req, bus_wr;
  logic [1:0]  bus_size;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_addr, bus_wdata;
  logic        bus_addr_ok, bus_data_ok;
  logic [31:0] bus_rdata;

  typedef struct {
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } rq_t;

  rq_t        rq [2];
  logic [1:0] exp_q [$];   // bit0 = owner id, bit1 = cancelled
  logic       lock_v, lock_own;
  int         n_cmp = 0;
  int         n_err = 0;

  mem_req_arbiter #(.DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_wstrb(inst_wstrb), .inst_addr(inst_addr), .inst_wdata(inst_wdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .flush(flush),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_wstrb(bus_wstrb),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic new_req(input int r);
    rq[r].req   = 1'b1;
    rq[r].wr    = 1'($urandom_range(0, 1));
    rq[r].size  = 2'($urandom_range(0, 2));
    rq[r].wstrb = 4'($urandom_range(0, 15));
    rq[r].addr  = $urandom;
    rq[r].wdata = $urandom;
  endtask

  task automatic drive();
    inst_req = rq[0].req; inst_wr = rq[0].wr; inst_size = rq[0].size;
    inst_wstrb = rq[0].wstrb; inst_addr = rq[0].addr; inst_wdata = rq[0].wdata;
    data_req = rq[1].req; data_wr = rq[1].wr; data_size = rq[1].size;
    data_wstrb = rq[1].wstrb; data_addr = rq[1].addr; data_wdata = rq[1].wdata;
  endtask

  // One clock cycle: drive at negedge, compare just after, update the model at posedge.
  task automatic step();
    logic       own, want, e_breq, e_hs, e_pop, e_fwd;
    logic [1:0] head;
    drive();
    #1;
    own    = lock_v ? lock_own : rq[1].req;
    want   = rq[own].req;
    e_breq = want && (exp_q.size() < DEPTH);
    e_hs   = e_breq && bus_addr_ok;
    e_pop  = bus_data_ok && (exp_q.size() != 0);
    head   = e_pop ? exp_q[0] : 2'b00;
    e_fwd  = e_pop && !head[1];
    check1("bus_req", bus_req, e_breq);
    check1("inst_addr_ok", inst_addr_ok, e_hs && !own);
    check1("data_addr_ok", data_addr_ok, e_hs && own);
    check1("inst_data_ok", inst_data_ok, e_fwd && !head[0]);
    check1("data_data_ok", data_data_ok, e_fwd && head[0]);
    if (e_breq) begin
      check32("bus_addr", bus_addr, rq[own].addr);
      check32("bus_wdata", bus_wdata, rq[own].wdata);
      check32("bus_ctl", {25'b0, bus_wr, bus_size, bus_wstrb},
              {25'b0, rq[own].wr, rq[own].size, rq[own].wstrb});
    end
    if (e_fwd) check32("rdata", head[0] ? data_rdata : inst_rdata, bus_rdata);
    @(posedge clk);
    if (e_pop) void'(exp_q.pop_front());
    if (e_hs) exp_q.push_back({1'b0, own});
`ifdef ARB_FLUSH_CANCEL_EN
    if (flush) foreach (exp_q[i]) if (exp_q[i][0] == 1'b0) exp_q[i][1] = 1'b1;
`endif
    if (e_hs) begin
      lock_v = 1'b0;
      rq[own].req = 1'b0;
    end else if (e_breq) begin
      lock_v   = 1'b1;
      lock_own = own;
    end
    @(negedge clk);
    bus_data_ok = 1'b0;
    flush       = 1'b0;
  endtask

  task automatic check_in_reset();
    drive();
    #1;
    check1("rst_bus_req", bus_req, 1'b0);
    check1("rst_inst_addr_ok", inst_addr_ok, 1'b0);
    check1("rst_data_addr_ok", data_addr_ok, 1'b0);
    check1("rst_inst_data_ok", inst_data_ok, 1'b0);
    check1("rst_data_data_ok", data_data_ok, 1'b0);
    exp_q.delete();
    lock_v = 1'b0;
  endtask

  initial begin
    resetn = 1'b0; flush = 1'b0;
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = '0;
    lock_v = 1'b0; lock_own = 1'b0;
    for (int r = 0; r < 2; r++) begin
      rq[r] = '{req: 1'b0, wr: 1'b0, size: 2'b0, wstrb: 4'b0, addr: 32'b0, wdata: 32'b0};
    end
    drive();
    repeat (2) @(negedge clk);

    // Reset holds all handshakes low even with both sides active.
    new_req(0); new_req(1);
    bus_addr_ok = 1'b1; bus_data_ok = 1'b1;
    check_in_reset();
    @(negedge clk);
    resetn = 1'b1; bus_data_ok = 1'b0;

    // Simultaneous requests: data first, inst next cycle.
    step(); step();
    for (int k = 0; k < 2; k++) begin bus_data_ok = 1'b1; bus_rdata = $urandom; step(); end

    // Locked inst request is not pre-empted by a later data request.
    new_req(0); bus_addr_ok = 1'b0;
    step(); new_req(1); step(); step();
    bus_addr_ok = 1'b1;
    step(); step();
    for (int k = 0; k < 2; k++) begin bus_data_ok = 1'b1; bus_rdata = $urandom; step(); end

    // Full queue blocks bus_req even with a same-cycle response.
    for (int k = 0; k < DEPTH; k++) begin new_req(0); step(); end
    new_req(1); step();
    bus_data_ok = 1'b1; bus_rdata = $urandom; step();
    step();
    for (int k = 0; k < DEPTH; k++) begin bus_data_ok = 1'b1; bus_rdata = $urandom; step(); end

    // In-order routing of responses.
    new_req(0); step(); new_req(1); step(); new_req(0); step();
    bus_data_ok = 1'b1; bus_rdata = 32'h11; step();
    bus_data_ok = 1'b1; bus_rdata = 32'h22; step();
    bus_data_ok = 1'b1; bus_rdata = 32'h33; step();

    // Flush with two inst reads in flight, then a fresh inst request.
    new_req(0); step(); new_req(0); step();
    flush = 1'b1; step();
    for (int k = 0; k < 2; k++) begin bus_data_ok = 1'b1; bus_rdata = $urandom; step(); end
    new_req(0); step();
    bus_data_ok = 1'b1; bus_rdata = $urandom; step();

    // Reset with three outstanding, then a stray response.
    new_req(0); step(); new_req(1); step(); new_req(0); step();
    resetn = 1'b0; new_req(0);
    check_in_reset();
    @(negedge clk);
    resetn = 1'b1;
    bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = $urandom; step();
    bus_addr_ok = 1'b1; step();
    bus_data_ok = 1'b1; bus_rdata = $urandom; step();

    // Random traffic with stray responses and flushes.
    repeat (800) begin
      for (int r = 0; r < 2; r++) if (!rq[r].req && ($urandom_range(0, 1) == 1)) new_req(r);
      bus_addr_ok = ($urandom_range(0, 3) != 0);
      bus_data_ok = ($urandom_range(0, 2) == 0);
      bus_rdata   = $urandom;
      flush       = ($urandom_range(0, 7) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_req_arbiter.md
MEM_REQ_ARBITER -- requirements
Module: mem_req_arbiter

Interface
REQ-001 Parameter DEPTH, default 4, maximum outstanding accepted-but-unanswered requests (power of 2, 2..8).
REQ-002 clk  input  1  sole clock, all state on rising edge.
REQ-003 resetn  input  1  asynchronous, active-low reset.
REQ-004 inst_req / data_req  input  1 each  requester request valid; inst = requester 0, data = requester 1.
REQ-005 inst_wr, inst_size[1:0], inst_wstrb[3:0], inst_addr[31:0], inst_wdata[31:0]  input  requester-0 request fields; data_* identical set for requester 1.
REQ-006 inst_addr_ok / data_addr_ok  output  1 each  request accepted this cycle.
REQ-007 inst_data_ok / data_data_ok  output  1 each  response delivered this cycle; inst_rdata / data_rdata  output  32  response data.
REQ-008 flush  input  1  pipeline flush; cancels in-flight inst responses.
REQ-009 bus_req, bus_wr, bus_size[1:0], bus_wstrb[3:0], bus_addr[31:0], bus_wdata[31:0]  output  shared SRAM-like request channel.
REQ-010 bus_addr_ok, bus_data_ok  input  1 each; bus_rdata  input  32; responses return strictly in request order.

Function
REQ-011 Grant: locked owner if lock valid; else data when data_req, else inst when inst_req.
REQ-012 bus_req SHALL equal (granted requester's req) AND (count < DEPTH); bus_wr/size/wstrb/addr/wdata SHALL be a combinational mux of the granted requester's fields.
REQ-013 Handshake = bus_req && bus_addr_ok; the granted requester's addr_ok SHALL be 1 exactly in handshake cycles, other addr_ok 0.
REQ-014 Lock SHALL be set with owner id when bus_req && !bus_addr_ok, cleared on handshake; a newer data_req SHALL NOT pre-empt a locked inst request.
REQ-015 Outstanding FIFO of DEPTH entries {id, cancel}: push on handshake, pop on bus_data_ok; wr/rd pointers wrap modulo DEPTH; count 0..DEPTH.
REQ-016 Full (count==DEPTH) SHALL block bus_req even if a pop occurs the same cycle; simultaneous push and pop when not full leaves count unchanged.
REQ-017 On bus_data_ok with non-empty FIFO: head id selects requester; that requester's data_ok = 1 unless head cancel set; rdata outputs both driven from bus_rdata.
REQ-018 bus_data_ok with empty FIFO SHALL be ignored (no data_ok, count stays 0).
REQ-019 Latency: addr_ok and data_ok are combinational from bus inputs, zero added cycles; one request and one response per cycle max.
REQ-020 Flush SHALL never drop or alter a pending bus_req (protocol requires holding).

Reset
REQ-021 resetn low SHALL immediately clear pointers, count, lock, all cancel bits; bus_req, all addr_ok, all data_ok SHALL read 0 while resetn low.
REQ-022 Responses for requests accepted before a mid-operation reset SHALL be discarded after release (FIFO empty).

Configuration
REQ-023 Macro ARB_FLUSH_CANCEL_EN defined: flush sets cancel on every valid FIFO entry with id inst (including an entry pushed that same cycle); cancelled pops generate no data_ok.
REQ-024 Macro undefined: cancel bits absent, flush ignored, every pop forwards data_ok.

Structure
REQ-025 Requester id encoding (INST_ID=0, DATA_ID=1) and the FIFO entry typedef SHALL live in the shared mycpu header/package.
REQ-026 One sub-module, arb_id_fifo (pointers, count, cancel-marking), SHALL hold the outstanding queue; grant/lock/mux logic stays in mem_req_arbiter.

Verification
REQ-027 Both req same cycle, bus_addr_ok=1: data_addr_ok=1, inst_addr_ok=0, bus_addr=data_addr; inst accepted next cycle.
REQ-028 inst_req with bus_addr_ok=0 for 3 cycles, data_req rises in cycle 2: bus_addr stays inst_addr until handshake, then data granted.
REQ-029 4 handshakes, no responses, DEPTH=4: 5th request sees bus_req=0; one bus_data_ok in the same cycle still keeps bus_req=0 that cycle, 1 the next.
REQ-030 Issue inst, data, inst; responses 0x11,0x22,0x33: inst_data_ok/rdata 0x11, data_data_ok 0x22, inst_data_ok 0x33.
REQ-031 ARB_FLUSH_CANCEL_EN: 2 inst outstanding, flush, then 2 bus_data_ok: no inst_data_ok; following new inst request answered normally; undefined: both forwarded.
REQ-032 resetn pulsed low with 3 outstanding: count 0, subsequent stray bus_data_ok produces no data_ok.
